// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS front end. The instruction fetch unit and
// the control decoder both import this package.
//   - opcode constants (instr[31:26]) for the supported instruction classes
//   - fetch FSM state type
//   - default reset PC
package mips_pkg;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// npc_calc
// Combinational next-PC selection for the instruction currently held by the
// fetch unit.
// Ports:
//   pc_plus4 [31:0] in  : address of the held instruction + 4
//   instr    [25:0] in  : low 26 bits of the held instruction (jump index and
//                         branch immediate both live here)
//   jump, branch, zero  : resolution from decoder / ALU
//   next_pc  [31:0] out : address of the following instruction
module npc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // Jump keeps the 256 MB region of pc_plus4; branch offset is a signed
    // word displacement. Both wrap naturally in 32-bit arithmetic.
    assign jump_target   = {pc_plus4[31:28], instr, 2'b00};
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

    // Jump wins over a taken branch when the decoder asserts both.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/ifetch.sv
// ifetch
// Instruction fetch unit: requests one word from instruction memory, holds it
// for the downstream stage until retired, then advances the PC (sequential,
// taken branch or jump) and counts the retirement. One instruction in flight.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req/imem_addr    : fetch request and address (= pc)
//   imem_ack/imem_rdata   : read completion and instruction word
//   instr/op/pc/pc_plus4  : registered instruction, opcode, its address, +4
//   instr_valid           : the above describe a live instruction
//   instr_ready           : downstream retires the presented instruction
//   jump/branch/zero      : next-PC resolution, sampled on the retire cycle
//   instr_count           : number of retired instructions (wraps)
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] instr_count
);

    // Low address bits of the reset vector are forced to word alignment.
    localparam logic [31:0] PC_INIT    = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] PC_INIT_P4 = PC_INIT + 32'd4;

    fetch_state_t state;
    logic [31:0]  next_pc;

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr[25:0]),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    assign imem_addr = pc;
    assign op        = instr[31:26];

    // imem_req and instr_valid are registered alongside the state so they
    // are glitch-free and match the state exactly. pc_plus4 is kept as its
    // own register so next-PC logic starts from a flop, not an adder chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= PC_INIT;
            pc_plus4    <= PC_INIT_P4;
            instr       <= 32'h0000_0000;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            instr_count <= 32'h0000_0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack && imem_req) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        pc_plus4    <= next_pc + 32'd4;
                        instr_count <= instr_count + 32'd1;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] ignored (treated as 0).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 imem_req  out  1  fetch request to instruction memory.
REQ-005 imem_addr  out  32  fetch address (= pc).
REQ-006 imem_ack  in  1  memory read complete; honoured only while imem_req=1.
REQ-007 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-008 instr  out  32  registered instruction presented downstream.
REQ-009 op  out  6  instr[31:26], opcode for the control decoder.
REQ-010 pc / pc_plus4  out  32 each  address of instr / that address + 4.
REQ-011 instr_valid  out  1  instr, op, pc, pc_plus4 hold a live instruction.
REQ-012 instr_ready  in  1  downstream retires the presented instruction this cycle.
REQ-013 jump, branch, zero  in  1 each  decoder/ALU resolution for the presented instruction.
REQ-014 instr_count  out  32  number of retired instructions.

Function
REQ-015 FSM states IDLE, FETCH, ISSUE; exactly one active.
REQ-016 IDLE: one-cycle bubble after reset release; imem_req=0; -> FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on imem_ack capture imem_rdata into instr -> ISSUE same edge (zero-wait memory permitted).
REQ-018 ISSUE: instr_valid=1, imem_req=0; instr/pc stable while instr_ready=0 (unbounded backpressure).
REQ-019 Retire = ISSUE and instr_ready=1: update pc to next-PC, increment instr_count, -> FETCH; instr_valid=0 next cycle.
REQ-020 Next-PC: jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch=1 and zero=1 -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-021 jump has priority over branch when both high.
REQ-022 jump/branch/zero sampled only on the retire cycle; ignored elsewhere.
REQ-023 All PC arithmetic modulo 2^32 (0xFFFF_FFFC + 4 = 0); pc[1:0] always 0.
REQ-024 instr_count wraps 0xFFFF_FFFF -> 0.
REQ-025 imem_ack while imem_req=0 ignored; no state change.
REQ-026 Throughput: minimum 2 cycles per instruction (FETCH with ack + ISSUE with ready); no overlap.
REQ-027 instr retains last value when instr_valid=0.

Reset
REQ-028 rst_n=0 asynchronously: state=IDLE, pc=RESET_PC, pc_plus4=RESET_PC+4, instr=0, instr_valid=0, imem_req=0, instr_count=0.
REQ-029 Reset mid-FETCH or mid-ISSUE discards the in-flight instruction; imem_ack during or immediately after reset not captured.

Structure
REQ-030 Shared package mips_pkg: opcode constants (R, LW, SW, BEQ, J), FSM state type, RESET_PC default; also used by control decoder.
REQ-031 One combinational sub-module npc_calc (pc_plus4, instr, jump, branch, zero -> next_pc); FSM, registers and counter in ifetch.

Verification
REQ-032 Reset, RESET_PC=0, ack same cycle as req, ready=1 -> imem_addr 0,4,8; instr_valid every second cycle; instr_count 1,2,3.
REQ-033 imem_ack 3 cycles after req -> imem_req held high, imem_addr constant 3 cycles, instr_valid=0 until capture.
REQ-034 instr_ready=0 for 4 cycles in ISSUE -> instr, pc, instr_count unchanged, imem_req=0; retire on 5th cycle.
REQ-035 BEQ at pc=0x10, imm=0xFFFC, branch=1 zero=1 -> next imem_addr 0x04; zero=0 -> 0x14; jump=1 with branch=1 -> jump target wins.
REQ-036 J at pc=0x4000_0000, instr[25:0]=0x100 -> next imem_addr 0x4000_0400; pc=0xFFFF_FFFC sequential -> 0x0000_0000.
REQ-037 rst_n low during FETCH wait with imem_ack pulsed during reset -> no capture; after release IDLE then imem_addr=RESET_PC, instr_count=0.
